// File: rtl/mist1032isa_sync_fifo_wr_arbiter_pkg.sv
// Shared constants for the FIFO write-port arbiter: requester count,
// ID width and flush FSM state encodings.
package mist1032isa_sync_fifo_wr_arbiter_pkg;

  localparam int REQ_N = 4;
  localparam int ID_W  = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_REMOVE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/mist1032isa_sync_fifo_wr_arbiter_rr.sv
// mist1032isa_rr_arbiter4: combinational 4-way round-robin picker.
// req_i/rr_i in; grant_o (one-hot), id_o, valid_o out.
module mist1032isa_rr_arbiter4
  import mist1032isa_sync_fifo_wr_arbiter_pkg::*;
(
  input  logic [REQ_N-1:0] req_i,
  input  logic [ID_W-1:0]  rr_i,
  output logic [REQ_N-1:0] grant_o,
  output logic [ID_W-1:0]  id_o,
  output logic             valid_o
);

  logic [ID_W-1:0] idx;

  // Scan from the farthest offset down so the
  // nearest requester after rr_i wins last.
  always_comb begin
    idx     = '0;
    id_o    = '0;
    valid_o = 1'b0;
    for (int i = REQ_N - 1; i >= 0; i--) begin
      idx = rr_i + ID_W'(i);
      if (req_i[idx]) begin
        valid_o = 1'b1;
        id_o    = idx;
      end
    end
  end

  assign grant_o = valid_o ? (REQ_N'(1) << id_o) : '0;

endmodule

// File: rtl/mist1032isa_sync_fifo_wr_arbiter.sv
// Round-robin share of one sync FIFO write port among 4 requesters,
// with ID tagging, full protection and sequenced flush (iREMOVE).
module mist1032isa_sync_fifo_wr_arbiter
  import mist1032isa_sync_fifo_wr_arbiter_pkg::*;
#(
  parameter int N     = 16,
  parameter int DEPTH = 4,
  parameter int D_N   = 2
)(
  input  logic                  iCLOCK,
  input  logic                  inRESET,
  input  logic [REQ_N-1:0]      iREQ_VALID,
  input  logic [REQ_N*N-1:0]    iREQ_DATA,
  output logic [REQ_N-1:0]      oREQ_ACK,
  input  logic                  iFLUSH_REQ,
  output logic                  oFLUSH_ACK,
  output logic                  oFIFO_REMOVE,
  output logic                  oFIFO_WR_EN,
  output logic [N+ID_W-1:0]     oFIFO_WR_DATA,
  input  logic                  iFIFO_FULL,
  input  logic [D_N-1:0]        iFIFO_COUNT
);

  localparam logic [D_N-1:0] CNT_LAST = D_N'(DEPTH - 1);

  logic [1:0]          state_q, state_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic                wr_en_q, wr_en_d;
  logic [N+ID_W-1:0]   wr_data_q, wr_data_d;
  logic                remove_q, remove_d;
  logic                fack_q, fack_d;

  logic [REQ_N-1:0]    grant;
  logic [ID_W-1:0]     gnt_id;
  logic                gnt_vld;
  logic                space_ok;
  logic                accept;

  mist1032isa_rr_arbiter4 u_rr (
    .req_i   (iREQ_VALID),
    .rr_i    (rr_q),
    .grant_o (grant),
    .id_o    (gnt_id),
    .valid_o (gnt_vld)
  );

  // COUNT==DEPTH-1 plus a write in flight means the
  // FIFO is full at the next edge.
  assign space_ok = !iFIFO_FULL &&
                    !(wr_en_q && iFIFO_COUNT == CNT_LAST);

  // Reset gates the combinational ack so every
  // output is low while inRESET is asserted.
  assign accept = inRESET && (state_q == ST_IDLE) &&
                  !iFLUSH_REQ && space_ok && gnt_vld;

  assign oREQ_ACK = accept ? grant : '0;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    wr_en_d   = accept;
    wr_data_d = wr_data_q;
    remove_d  = 1'b0;
    fack_d    = 1'b0;
    if (accept) begin
      wr_data_d = {gnt_id, iREQ_DATA[gnt_id*N +: N]};
      rr_d      = gnt_id + ID_W'(1);
    end
    unique case (state_q)
      ST_IDLE: begin
        if (iFLUSH_REQ) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!wr_en_q) begin
          state_d  = ST_REMOVE;
          remove_d = 1'b1;
        end
      end
      ST_REMOVE: begin
        state_d = ST_DONE;
        fack_d  = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q   <= ST_IDLE;
      rr_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      remove_q  <= 1'b0;
      fack_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      remove_q  <= remove_d;
      fack_q    <= fack_d;
    end
  end

  assign oFIFO_WR_EN   = wr_en_q;
  assign oFIFO_WR_DATA = wr_data_q;
  assign oFIFO_REMOVE  = remove_q;
  assign oFLUSH_ACK    = fack_q;

endmodule

// File: tb/tb_mist1032isa_sync_fifo_wr_arbiter.sv
// Scoreboard bench for mist1032isa_sync_fifo_wr_arbiter with a
// behavioural FIFO and arbitration/flush timeline model.
module tb_mist1032isa_sync_fifo_wr_arbiter;

  logic        iCLOCK = 1'b0;
  logic        inRESET = 1'b0;
  logic [3:0]  iREQ_VALID = '0;
  logic [63:0] iREQ_DATA = '0;
  logic [3:0]  oREQ_ACK;
  logic        iFLUSH_REQ = 1'b0;
  logic        oFLUSH_ACK;
  logic        oFIFO_REMOVE;
  logic        oFIFO_WR_EN;
  logic [17:0] oFIFO_WR_DATA;
  logic        iFIFO_FULL = 1'b0;
  logic [1:0]  iFIFO_COUNT = '0;

  always #5 iCLOCK = ~iCLOCK;

  mist1032isa_sync_fifo_wr_arbiter #(
    .N(16), .DEPTH(4), .D_N(2)
  ) dut (
    .iCLOCK        (iCLOCK),
    .inRESET       (inRESET),
    .iREQ_VALID    (iREQ_VALID),
    .iREQ_DATA     (iREQ_DATA),
    .oREQ_ACK      (oREQ_ACK),
    .iFLUSH_REQ    (iFLUSH_REQ),
    .oFLUSH_ACK    (oFLUSH_ACK),
    .oFIFO_REMOVE  (oFIFO_REMOVE),
    .oFIFO_WR_EN   (oFIFO_WR_EN),
    .oFIFO_WR_DATA (oFIFO_WR_DATA),
    .iFIFO_FULL    (iFIFO_FULL),
    .iFIFO_COUNT   (iFIFO_COUNT)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  req_v;
  logic [15:0] req_d [4];
  logic        flush_r, pop_r, force_full;
  int          mode;
  logic [17:0] sb [$];
  logic [17:0] fq [$];
  int          m_rr, m_inflight, m_ft, cyc;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge iCLOCK) begin
    if (inRESET && oFIFO_WR_EN) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wr_unexpected: got %0h expected none",
                 oFIFO_WR_DATA);
      end else begin
        chk("wr_data", 32'(oFIFO_WR_DATA), 32'(sb.pop_front()));
      end
    end
  end

  task automatic drive();
    iREQ_VALID = req_v;
    for (int k = 0; k < 4; k++) iREQ_DATA[k*16 +: 16] = req_d[k];
    iFLUSH_REQ  = flush_r;
    iFIFO_FULL  = force_full || (fq.size() == 4);
    iFIFO_COUNT = force_full ? 2'd0 : 2'(fq.size());
  endtask

  task automatic model_reset();
    m_rr = 0;
    m_inflight = 0;
    m_ft = -1;
    flush_r = 1'b0;
    sb.delete();
    fq.delete();
  endtask

  // One clock cycle: drive, predict and check at negedge,
  // then let the FIFO model react to the edge.
  task automatic tick();
    int k;
    bit acc, e_rm, e_fa, wr, rm, do_pop;
    logic [3:0]  e_ack;
    logic [17:0] wd;
    drive();
    @(negedge iCLOCK);
    k = -1;
    acc = 0;
    e_rm = 0;
    e_fa = 0;
    if (m_ft >= 0) begin
      e_rm = (cyc == m_ft + 2);
      e_fa = (cyc == m_ft + 3);
    end else if (flush_r) begin
      m_ft = cyc;
    end else begin
      for (int i = 0; i < 4; i++)
        if (k < 0 && req_v[(m_rr + i) % 4]) k = (m_rr + i) % 4;
      acc = (k >= 0) && !force_full &&
            (fq.size() + m_inflight < 4);
    end
    e_ack = acc ? 4'(1 << k) : 4'b0;
    chk("ack", 32'(oREQ_ACK), 32'(e_ack));
    chk("wr_en", 32'(oFIFO_WR_EN), 32'(m_inflight));
    chk("remove", 32'(oFIFO_REMOVE), 32'(e_rm));
    chk("flush_ack", 32'(oFLUSH_ACK), 32'(e_fa));
    if (e_fa) begin
      chk("fifo_empty_after_flush", 32'(fq.size()), 32'd0);
      m_ft = -1;
    end
    wr = oFIFO_WR_EN;
    wd = oFIFO_WR_DATA;
    rm = oFIFO_REMOVE;
    @(posedge iCLOCK);
    do_pop = pop_r && fq.size() > 0;
    if (wr) begin
      if (fq.size() >= 4) begin
        n_checks++;
        n_fail++;
        $display("FAIL overflow: got write %0h expected none", wd);
      end else begin
        fq.push_back(wd);
      end
    end
    if (do_pop) void'(fq.pop_front());
    if (rm) fq.delete();
    if (acc) begin
      sb.push_back({2'(k), req_d[k]});
      m_rr = (k + 1) % 4;
      if (mode == 0) req_v[k] = 1'b0;
      else if (mode == 2) req_v[k] = 1'($urandom_range(0, 1));
      req_d[k] = 16'($urandom);
    end
    m_inflight = acc ? 1 : 0;
    if (e_fa) flush_r = 1'b0;
    cyc++;
    #1;
  endtask

  initial begin
    req_v = '0;
    for (int k = 0; k < 4; k++) req_d[k] = '0;
    pop_r = 1'b1;
    force_full = 1'b0;
    mode = 0;
    cyc = 0;
    model_reset();
    drive();
    #3;
    chk("rst_ack", 32'(oREQ_ACK), 32'd0);
    chk("rst_wr_en", 32'(oFIFO_WR_EN), 32'd0);
    chk("rst_wr_data", 32'(oFIFO_WR_DATA), 32'd0);
    chk("rst_remove", 32'(oFIFO_REMOVE), 32'd0);
    chk("rst_flush_ack", 32'(oFLUSH_ACK), 32'd0);
    @(posedge iCLOCK);
    #1;
    inRESET = 1'b1;

    // single requester 2, then rr must point at 3
    req_v = 4'b0100;
    req_d[2] = 16'hBEEF;
    tick();
    tick();
    req_v = 4'b1001;
    tick();
    tick();
    tick();

    // all valid, FIFO drained each cycle
    mode = 1;
    req_v = 4'b1111;
    repeat (8) tick();

    // FIFO fills with requester 1, then reader pops
    req_v = 4'b0000;
    repeat (6) tick();
    pop_r = 1'b0;
    req_v = 4'b0010;
    repeat (6) tick();
    pop_r = 1'b1;
    repeat (3) tick();

    // flush with requester 0 valid and a write in flight
    req_v = 4'b0000;
    repeat (6) tick();
    req_v = 4'b0001;
    tick();
    flush_r = 1'b1;
    repeat (6) tick();

    // FIFO forced full with every requester valid
    req_v = 4'b0000;
    tick();
    force_full = 1'b1;
    req_v = 4'b1111;
    repeat (10) tick();
    force_full = 1'b0;
    req_v = 4'b0000;
    repeat (6) tick();

    // reset asserted during REMOVE
    req_v = 4'b0100;
    tick();
    req_v = 4'b1111;
    flush_r = 1'b1;
    for (int g = 0; g < 10; g++)
      if (!(m_ft >= 0 && cyc == m_ft + 2)) tick();
    chk("remove_before_reset", 32'(oFIFO_REMOVE), 32'd1);
    inRESET = 1'b0;
    #1;
    chk("arst_ack", 32'(oREQ_ACK), 32'd0);
    chk("arst_remove", 32'(oFIFO_REMOVE), 32'd0);
    chk("arst_wr_en", 32'(oFIFO_WR_EN), 32'd0);
    chk("arst_wr_data", 32'(oFIFO_WR_DATA), 32'd0);
    chk("arst_flush_ack", 32'(oFLUSH_ACK), 32'd0);
    model_reset();
    drive();
    @(posedge iCLOCK);
    #1;
    inRESET = 1'b1;
    repeat (5) tick();

    // randomized traffic with occasional flushes
    mode = 2;
    req_v = 4'b0000;
    for (int c = 0; c < 500; c++) begin
      for (int k = 0; k < 4; k++)
        if (!req_v[k] && $urandom_range(0, 2) == 0) begin
          req_v[k] = 1'b1;
          req_d[k] = 16'($urandom);
        end
      pop_r = 1'($urandom_range(0, 1));
      if (m_ft < 0 && !flush_r && $urandom_range(0, 19) == 0)
        flush_r = 1'b1;
      tick();
    end
    req_v = 4'b0000;
    repeat (6) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
